// File: rtl/multi_counter_sweep.sv
// Command-side controller for multi_counter: merges inc/dec events with an INIT/QRY sweep
// and streams query responses through a credit-protected FIFO.
package multi_counter_pkg;
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INIT = 3'd1,
        OP_INCR = 3'd2,
        OP_DECR = 3'd3,
        OP_QRY  = 3'd4
    } op_t;
endpackage

// state | meaning
// IDLE  | events only, waiting for sweep_start
// INIT  | clearing every counter, events held off
// QRY   | querying counters in id order, events take priority
// DRAIN | all queries issued, waiting for in-flight responses
module multi_counter_sweep
    import multi_counter_pkg::*;
#(
    parameter int CNTRS_N    = 256,
    parameter int CNTRS_W    = 32,
    parameter int CNTRS_ID_W = $clog2(CNTRS_N),
    parameter int FIFO_N     = 8,
    parameter int RSP_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sweep_start,
    input  logic                  sweep_clr,
    output logic                  sweep_busy_r,
    output logic                  sweep_done_r,
    input  logic                  evt_vld,
    output logic                  evt_rdy,
    input  logic [CNTRS_ID_W-1:0] evt_id,
    input  logic                  evt_dec,
    output logic                  cntr_pass_r,
    output logic [CNTRS_ID_W-1:0] cntr_id_r,
    output op_t                   cntr_op_r,
    output logic [CNTRS_W-1:0]    cntr_dat_r,
    input  logic                  status_pass_r,
    input  logic                  status_qry_r,
    input  logic [CNTRS_ID_W-1:0] status_id_r,
    input  logic [CNTRS_W-1:0]    status_dat_r,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [CNTRS_ID_W-1:0] out_id,
    output logic [CNTRS_W-1:0]    out_dat,
    output logic [7:0]            drop_cnt_r
);
    localparam int FIFO_AW = $clog2(FIFO_N);
    localparam int CNT_W   = FIFO_AW + 1;
    localparam int OUT_W   = $clog2(RSP_LAT + 1);
    localparam int CMP_W   = CNT_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_QRY, ST_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNTRS_ID_W-1:0] r_ptr;
    logic [OUT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_fifo_cnt;
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [CNTRS_ID_W-1:0] r_mem_id  [FIFO_N];
    logic [CNTRS_W-1:0]    r_mem_dat [FIFO_N];
    logic                  r_sweep_busy;
    logic                  r_sweep_done;
    logic                  r_cntr_pass;
    logic [CNTRS_ID_W-1:0] r_cntr_id;
    op_t                   r_cntr_op;
    logic [CNTRS_W-1:0]    r_cntr_dat;
    logic [7:0]            r_drop_cnt;

    logic w_evt_acc;
    logic w_init_issue;
    logic w_qry_issue;
    logic w_done_nxt;
    logic w_last;
    logic w_credit;
    logic w_ptr_clr;
    logic w_rsp;
    logic w_push;
    logic w_drop;
    logic w_pop;

    assign evt_rdy   = (r_state != ST_INIT);
    assign w_evt_acc = evt_vld & evt_rdy;
    assign w_last    = (r_ptr == CNTRS_ID_W'(CNTRS_N - 1));
    // in-flight queries reserve FIFO space so a response is never refused
    assign w_credit  = (CMP_W'(r_fifo_cnt) + CMP_W'(r_outstanding)) < CMP_W'(FIFO_N);
    assign w_rsp     = status_pass_r & status_qry_r;
    assign w_push    = w_rsp & (r_outstanding != '0);
    assign w_drop    = w_rsp & (r_outstanding == '0);
    assign w_pop     = out_vld & out_rdy;
    assign w_ptr_clr = ((r_state == ST_IDLE) & sweep_start) | ((r_state == ST_INIT) & w_last);

    always_comb begin
        w_state_nxt  = r_state;
        w_init_issue = 1'b0;
        w_qry_issue  = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sweep_start) w_state_nxt = sweep_clr ? ST_INIT : ST_QRY;
            end
            ST_INIT: begin
                w_init_issue = 1'b1;
                if (w_last) w_state_nxt = ST_QRY;
            end
            ST_QRY: begin
                w_qry_issue = ~w_evt_acc & w_credit;
                if (w_qry_issue && w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_outstanding == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_sweep_busy <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sweep_done <= w_done_nxt;
            if (w_ptr_clr) r_ptr <= '0;
            else if (w_init_issue || w_qry_issue) r_ptr <= r_ptr + CNTRS_ID_W'(1);
            // a new start in the done cycle wins over the clear
            if ((r_state == ST_IDLE) && sweep_start) r_sweep_busy <= 1'b1;
            else if (r_sweep_done) r_sweep_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntr_pass <= 1'b0;
            r_cntr_id   <= '0;
            r_cntr_op   <= OP_NOP;
            r_cntr_dat  <= '0;
        end else begin
            r_cntr_dat <= '0;
            if (w_evt_acc) begin
                r_cntr_pass <= 1'b1;
                r_cntr_id   <= evt_id;
                r_cntr_op   <= evt_dec ? OP_DECR : OP_INCR;
            end else if (w_init_issue || w_qry_issue) begin
                r_cntr_pass <= 1'b1;
                r_cntr_id   <= r_ptr;
                r_cntr_op   <= w_init_issue ? OP_INIT : OP_QRY;
            end else begin
                r_cntr_pass <= 1'b0;
                r_cntr_id   <= '0;
                r_cntr_op   <= OP_NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_fifo_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_qry_issue && !w_push) r_outstanding <= r_outstanding + OUT_W'(1);
            else if (!w_qry_issue && w_push) r_outstanding <= r_outstanding - OUT_W'(1);
            if (w_push && !w_pop) r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr_ptr]  <= status_id_r;
            r_mem_dat[r_wr_ptr] <= status_dat_r;
        end
    end

    assign sweep_busy_r = r_sweep_busy;
    assign sweep_done_r = r_sweep_done;
    assign cntr_pass_r  = r_cntr_pass;
    assign cntr_id_r    = r_cntr_id;
    assign cntr_op_r    = r_cntr_op;
    assign cntr_dat_r   = r_cntr_dat;
    assign drop_cnt_r   = r_drop_cnt;
    assign out_vld      = (r_fifo_cnt != '0);
    assign out_id       = r_mem_id[r_rd_ptr];
    assign out_dat      = r_mem_dat[r_rd_ptr];
endmodule
